// File: rtl/cv32e40p_formal_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40p_formal_pkg
//
// Declarations shared by the OBI instruction responder and its response
// FIFO:
//   NOP_INSN      - instruction returned for fetches outside the memory
//   IDX_W, AGE_W  - field widths of a FIFO entry
//   resp_entry_t  - one granted-but-unanswered fetch (index, in_range, age)
//   age_step()    - saturating age increment used by the FIFO
// ---------------------------------------------------------------------------
package cv32e40p_formal_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // The index field is wide enough for any word index a 32-bit byte
    // address can carry, so the struct does not depend on MEM_WORDS.
    localparam int unsigned IDX_W = 30;

    // Ages saturate at MIN_LATENCY, which tops out at 15.
    localparam int unsigned AGE_W = 4;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             in_range;
        logic [AGE_W-1:0] age;
    } resp_entry_t;

    // Count up by one and stick at the saturation value.
    function automatic logic [AGE_W-1:0] age_step(input logic [AGE_W-1:0] age,
                                                  input logic [AGE_W-1:0] sat);
        return (age >= sat) ? sat : age + AGE_W'(1);
    endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// ---------------------------------------------------------------------------
// obi_resp_fifo
//
// In-order FIFO of pending instruction responses. Every stored entry keeps
// an age counter that rises once per cycle and saturates at MIN_LATENCY;
// the head is reported ready once its age reaches MIN_LATENCY.
//
// Ports
//   clk_i          clock
//   rst_ni         synchronous active-low reset, empties the FIFO
//   push_i         store push_entry_i at the tail (ignored when full)
//   push_entry_i   entry to store; its age field is expected to be 0
//   pop_i          drop the head (ignored when empty)
//   head_o         current head entry
//   head_ready_o   FIFO non-empty and head age >= MIN_LATENCY
//   count_o        number of stored entries
// ---------------------------------------------------------------------------
module obi_resp_fifo
    import cv32e40p_formal_pkg::*;
#(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned MIN_LATENCY = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  resp_entry_t                  push_entry_i,
    input  logic                         pop_i,
    output resp_entry_t                  head_o,
    output logic                         head_ready_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(MIN_LATENCY);

    resp_entry_t            entries_q [DEPTH];
    logic [PTR_W-1:0]       wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]       rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   pushOk;
    logic                   popOk;
    resp_entry_t            pushAged;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state for pointers and occupancy. A simultaneous push and pop
    // leaves the count unchanged. The pushed entry is cleared to age 0 in
    // its grant cycle and takes its first step on the same edge that stores
    // it, so the stored age always equals cycles elapsed since the grant.
    always_comb begin
        pushOk   = push_i & (count_q != CNT_W'(DEPTH));
        popOk    = pop_i & (count_q != '0);
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        pushAged = push_entry_i;
        pushAged.age = age_step(push_entry_i.age, AGE_SAT);
        if (pushOk) begin
            wrPtr_d = ptrInc(wrPtr_q);
        end
        if (popOk) begin
            rdPtr_d = ptrInc(rdPtr_q);
        end
        case ({pushOk, popOk})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset only has to empty the FIFO, so the payload array
    // below is left alone.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Payload and ages. Empty slots age as well, which is harmless because
    // a slot is fully overwritten when it is pushed.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_q[i].age <= age_step(entries_q[i].age, AGE_SAT);
        end
        if (pushOk) begin
            entries_q[wrPtr_q] <= pushAged;
        end
    end

    assign head_o       = entries_q[rdPtr_q];
    assign head_ready_o = (count_q != '0) && (entries_q[rdPtr_q].age >= AGE_SAT);
    assign count_o      = count_q;

endmodule

// File: rtl/obi_insn_responder.sv
// ---------------------------------------------------------------------------
// obi_insn_responder
//
// OBI instruction-side slave model with a preloadable word memory, a bounded
// number of outstanding fetches and a minimum grant-to-response latency.
// Both the grant and the response can be throttled from outside.
//
// Parameters
//   MAX_OUTSTANDING  granted-but-unanswered fetches allowed (1..8)
//   MIN_LATENCY      minimum cycles from grant to rvalid (1..15)
//   MEM_WORDS        32-bit words in the memory (power of two)
//
// Ports
//   clk_i            clock
//   rst_ni           synchronous active-low reset
//   instr_req_i      OBI request
//   instr_addr_i     fetch byte address
//   instr_gnt_o      OBI grant
//   instr_rvalid_o   OBI response valid
//   instr_rdata_o    response data (0 when no response)
//   gnt_stall_i      withhold the grant this cycle
//   rvalid_stall_i   withhold the response this cycle
//   load_we_i        memory preload write enable
//   load_addr_i      preload word index
//   load_data_i      preload data
// ---------------------------------------------------------------------------
module obi_insn_responder
    import cv32e40p_formal_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned MIN_LATENCY     = 1,
    parameter int unsigned MEM_WORDS       = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          instr_req_i,
    input  logic [31:0]                   instr_addr_i,
    output logic                          instr_gnt_o,
    output logic                          instr_rvalid_o,
    output logic [31:0]                   instr_rdata_o,
    input  logic                          gnt_stall_i,
    input  logic                          rvalid_stall_i,
    input  logic                          load_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0]  load_addr_i,
    input  logic [31:0]                   load_data_i
);

    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]       mem_q [MEM_WORDS];
    resp_entry_t       pushEntry;
    resp_entry_t       headEntry;
    logic              headReady;
    logic [CNT_W-1:0]  outstanding;
    logic              headUnused;

    obi_resp_fifo #(
        .DEPTH       (MAX_OUTSTANDING),
        .MIN_LATENCY (MIN_LATENCY)
    ) u_resp_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (instr_gnt_o),
        .push_entry_i (pushEntry),
        .pop_i        (instr_rvalid_o),
        .head_o       (headEntry),
        .head_ready_o (headReady),
        .count_o      (outstanding)
    );

    // Grant and response. The grant looks only at the registered occupancy,
    // so a pop in the same cycle never frees a slot for an immediate grant.
    // Both are forced low during reset so entries granted before reset can
    // never be answered.
    always_comb begin
        instr_gnt_o    = rst_ni & instr_req_i & ~gnt_stall_i
                         & (outstanding < CNT_W'(MAX_OUTSTANDING));
        instr_rvalid_o = rst_ni & headReady & ~rvalid_stall_i;
    end

    // Entry captured on a grant: word index plus a flag telling whether the
    // upper address bits fall inside the memory.
    always_comb begin
        pushEntry          = '0;
        pushEntry.index    = IDX_W'(instr_addr_i[AW+1:2]);
        pushEntry.in_range = (instr_addr_i[31:AW+2] == '0);
        pushEntry.age      = '0;
    end

    // Response data is read from memory in the response cycle, so a preload
    // to the same word in that cycle is not yet visible.
    always_comb begin
        instr_rdata_o = 32'h0;
        if (instr_rvalid_o) begin
            instr_rdata_o = headEntry.in_range ? mem_q[headEntry.index[AW-1:0]]
                                               : NOP_INSN;
        end
    end

    // Preload port. The memory has no reset so a program survives a core
    // reset, and writes are accepted while reset is held.
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            mem_q[load_addr_i] <= load_data_i;
        end
    end

    assign headUnused = ^{headEntry.age, headEntry.index[IDX_W-1:AW], instr_addr_i[1:0]};

endmodule

// File: tb/tb_obi_insn_responder.sv
// ---------------------------------------------------------------------------
// tb_obi_insn_responder
//
// Directed scenarios followed by a randomized phase, all checked cycle by
// cycle against a transaction-level model: a queue of pending fetches tagged
// with their grant cycle and an array mirroring the memory.
// ---------------------------------------------------------------------------
module tb_obi_insn_responder;

    localparam int MAXO = 2;
    localparam int MINL = 1;
    localparam int MEMW = 1024;

    localparam logic [31:0] WORD0 = 32'h0010_0093;
    localparam logic [31:0] WORDA = 32'h0020_8113;
    localparam logic [31:0] WORDB = 32'h0031_0193;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        gnt_stall_i;
    logic        rvalid_stall_i;
    logic        load_we_i;
    logic [9:0]  load_addr_i;
    logic [31:0] load_data_i;

    typedef struct {
        int unsigned word;
        bit          inRange;
        int          grantCycle;
    } pending_t;

    pending_t    pendQ[$];
    logic [31:0] modelMem [MEMW];
    int          cycle  = 0;
    int          checks = 0;
    int          passes = 0;
    logic        expGnt;
    logic        expRvalid;
    logic [31:0] expRdata;

    always #5 clk_i = ~clk_i;

    obi_insn_responder #(
        .MAX_OUTSTANDING (MAXO),
        .MIN_LATENCY     (MINL),
        .MEM_WORDS       (MEMW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .gnt_stall_i    (gnt_stall_i),
        .rvalid_stall_i (rvalid_stall_i),
        .load_we_i      (load_we_i),
        .load_addr_i    (load_addr_i),
        .load_data_i    (load_data_i)
    );

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s cycle %0d: observed %h expected %h",
                    tag, cycle, observed, expected);
    endtask

    // Drive one cycle of inputs just after the clock edge, then move to the
    // falling edge where outputs are sampled.
    task automatic applyStimulus(input logic rst, input logic req,
                                 input logic [31:0] addr, input logic gs,
                                 input logic rs, input logic we,
                                 input logic [9:0] la, input logic [31:0] ld);
        rst_ni         = rst;
        instr_req_i    = req;
        instr_addr_i   = addr;
        gnt_stall_i    = gs;
        rvalid_stall_i = rs;
        load_we_i      = we;
        load_addr_i    = la;
        load_data_i    = ld;
        #4;
    endtask

    // Compare outputs with the model, then advance model and DUT by one edge.
    task automatic checkOutput();
        pending_t p;
        expGnt    = rst_ni && instr_req_i && !gnt_stall_i && (pendQ.size() < MAXO);
        expRvalid = rst_ni && (pendQ.size() > 0) && !rvalid_stall_i
                    && ((cycle - pendQ[0].grantCycle) >= MINL);
        expRdata  = 32'h0;
        if (expRvalid) begin
            expRdata = pendQ[0].inRange ? modelMem[pendQ[0].word] : NOP;
        end
        checkValue("gnt",    {31'b0, instr_gnt_o},    {31'b0, expGnt});
        checkValue("rvalid", {31'b0, instr_rvalid_o}, {31'b0, expRvalid});
        checkValue("rdata",  instr_rdata_o,           expRdata);

        if (!rst_ni) begin
            pendQ.delete();
        end else begin
            if (expRvalid) void'(pendQ.pop_front());
            if (expGnt) begin
                p.word       = int'(instr_addr_i[11:2]);
                p.inRange    = (instr_addr_i[31:12] == 20'h0);
                p.grantCycle = cycle;
                pendQ.push_back(p);
            end
        end
        if (load_we_i) modelMem[load_addr_i] = load_data_i;

        @(posedge clk_i);
        cycle++;
        #1;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        @(posedge clk_i);
        #1;

        // Preload the first 16 words while reset is held.
        for (int i = 0; i < 16; i++) begin
            d = (i == 0) ? WORD0 : (i == 1) ? WORDA : (i == 2) ? WORDB : $urandom;
            applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 10'(i), d);
            checkValue("reset_gnt", {31'b0, instr_gnt_o}, 32'h0);
            checkValue("reset_rdata", instr_rdata_o, 32'h0);
            checkOutput();
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkOutput();

        // Single fetch with minimum latency.
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkValue("s1_gnt", {31'b0, instr_gnt_o}, 32'h1);
        checkValue("s1_no_same_cycle_rvalid", {31'b0, instr_rvalid_o}, 32'h0);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkValue("s1_rdata", instr_rdata_o, WORD0);
        checkOutput();

        // Grant stall for three cycles, then the grant.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
            checkValue("s2_stalled_gnt", {31'b0, instr_gnt_o}, 32'h0);
            checkOutput();
        end
        applyStimulus(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkValue("s2_gnt", {31'b0, instr_gnt_o}, 32'h1);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkOutput();

        // Fill to MAX_OUTSTANDING under response stall, then drain.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 10'h0, 32'h0);
            if (k >= MAXO) checkValue("s3_full_gnt", {31'b0, instr_gnt_o}, 32'h0);
            checkOutput();
        end
        applyStimulus(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkValue("s3_no_pop_to_gnt", {31'b0, instr_gnt_o}, 32'h0);
        checkValue("s3_first_pop", {31'b0, instr_rvalid_o}, 32'h1);
        checkOutput();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
            checkOutput();
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
            checkOutput();
        end

        // Back-to-back fetches, grant and response overlap.
        applyStimulus(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkOutput();
        applyStimulus(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkValue("s4_overlap_gnt", {31'b0, instr_gnt_o}, 32'h1);
        checkValue("s4_data_a", instr_rdata_o, WORDA);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkValue("s4_data_b", instr_rdata_o, WORDB);
        checkOutput();

        // Out-of-range fetch answers with a NOP.
        applyStimulus(1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkValue("s5_nop", instr_rdata_o, NOP);
        checkOutput();

        // Reset with two fetches pending discards them.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 10'h0, 32'h0);
            checkOutput();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkValue("s6_reset_rvalid", {31'b0, instr_rvalid_o}, 32'h0);
        checkOutput();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
            checkValue("s6_no_stale_rvalid", {31'b0, instr_rvalid_o}, 32'h0);
            checkOutput();
        end
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkOutput();
        applyStimulus(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkValue("s6_mem_kept_0", instr_rdata_o, WORD0);
        checkOutput();
        applyStimulus(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkValue("s6_mem_kept_a", instr_rdata_o, WORDA);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        checkValue("s6_mem_kept_b", instr_rdata_o, WORDB);
        checkOutput();

        // Randomized traffic, stalls, preloads and occasional resets.
        for (int k = 0; k < 400; k++) begin
            a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[31 - $urandom_range(0, 19)] = 1'b1;
            applyStimulus($urandom_range(0, 49) != 0,
                          $urandom_range(0, 3) != 0,
                          a,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0,
                          10'($urandom_range(0, 15)),
                          $urandom);
            checkOutput();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/obi_insn_responder.md
OBI_INSN_RESPONDER -- requirements
Module: obi_insn_responder

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of granted-but-unanswered requests (legal range 1..8).
REQ-002 SHALL have parameter MIN_LATENCY, default 1, meaning the minimum number of cycles from a grant to its rvalid (legal range 1..15).
REQ-003 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 32-bit words in the internal instruction memory (power of 2).
REQ-004 Ports, in this order:
- clk_i, input, 1, clock.
- rst_ni, input, 1, reset; synchronous, active-low.
- instr_req_i, input, 1, OBI request from the core.
- instr_addr_i, input, 32, byte address of the fetch.
- instr_gnt_o, output, 1, OBI grant.
- instr_rvalid_o, output, 1, OBI response valid.
- instr_rdata_o, output, 32, response data.
- gnt_stall_i, input, 1, suppresses grant this cycle.
- rvalid_stall_i, input, 1, suppresses response this cycle.
- load_we_i, input, 1, memory preload write enable.
- load_addr_i, input, $clog2(MEM_WORDS), preload word index.
- load_data_i, input, 32, preload data.

Function
REQ-005 instr_gnt_o SHALL equal instr_req_i & !gnt_stall_i & (outstanding < MAX_OUTSTANDING), combinationally; it is never high while instr_req_i is low.
REQ-006 On each grant, the block SHALL push word index instr_addr_i[$clog2(MEM_WORDS)+1:2], an "in range" flag (instr_addr_i[31:$clog2(MEM_WORDS)+2]==0) and an age counter cleared to 0 into an in-order FIFO of depth MAX_OUTSTANDING.
REQ-007 Each valid entry's age counter SHALL increment every cycle and saturate at MIN_LATENCY.
REQ-008 instr_rvalid_o SHALL be high for exactly one cycle per entry, when all of the following hold: the FIFO is non-empty, the head's age is at least MIN_LATENCY, and rvalid_stall_i is low. The head is popped in that cycle.
REQ-009 Responses SHALL return in grant order. rvalid SHALL never occur in the same cycle as the grant of its own entry.
REQ-010 instr_rdata_o SHALL be mem[index] when the head entry is in range, 32'h0000_0013 (NOP) when it is out of range, and 32'h0 whenever instr_rvalid_o is low.
REQ-011 A grant and an rvalid in the same cycle SHALL push and pop together, leaving outstanding unchanged. Read and write pointers wrap modulo MAX_OUTSTANDING.
REQ-012 When the FIFO is full, instr_gnt_o SHALL be 0 regardless of instr_req_i. A pop in the same cycle SHALL NOT enable a grant that cycle; there is no combinational pop-to-grant path.
REQ-013 Memory is read at response time. A load_we_i write SHALL take effect at the next clock edge, so a same-cycle response to that word returns the old data.
REQ-014 The outstanding count SHALL never exceed MAX_OUTSTANDING and never underflow.

Reset
REQ-015 While rst_ni is low at a clock edge, the block SHALL:
- empty the FIFO;
- set outstanding to 0, instr_gnt_o to 0, instr_rvalid_o to 0 and instr_rdata_o to 0.
REQ-016 Reset asserted mid-transaction SHALL discard all pending responses; no rvalid is issued for entries granted before reset.
REQ-017 Memory contents SHALL NOT be cleared by reset. load_we_i SHALL be honoured while in reset.

Structure
REQ-018 The NOP constant and the FIFO entry struct (index, in_range, age) SHALL live in the shared package cv32e40p_formal_pkg.
REQ-019 The in-order FIFO with age counters SHALL be a sub-module obi_resp_fifo. Grant logic, memory array and data mux SHALL stay in the top module.

Verification
REQ-020 Bench scenarios:
- Preload mem[0]=32'h0010_0093. Req at addr 0x0, no stalls, MIN_LATENCY=1 -> gnt in cycle 0, rvalid with rdata 32'h0010_0093 in cycle 1.
- Req held with gnt_stall_i=1 for 3 cycles -> gnt_o=0 throughout; gnt on cycle 4.
- MAX_OUTSTANDING=2, req held high, rvalid_stall_i=1 -> exactly 2 grants, then gnt=0. Release the stall -> 2 in-order rvalids; the next grant comes no earlier than the cycle after the first pop.
- Back-to-back addresses 0x4 then 0x8 with mem[1]=A and mem[2]=B -> rvalid data sequence A then B. A grant and an rvalid observed in the same cycle keep outstanding at 1.
- Req to addr 0x8000_0000 -> rvalid with rdata 32'h0000_0013.
- Two grants pending, then rst_ni=0 for 1 cycle -> no rvalid afterwards; outstanding=0; memory still reads its preloaded values.
